// File: rtl/centroid_pkg.sv
// Shared width helpers and divider-sequencer state encoding for the banded
// centroid tracker.
package centroid_pkg;

    function automatic int x_w(input int img_w);
        return $clog2(img_w);
    endfunction

    function automatic int cnt_w(input int img_w, input int band_h);
        return $clog2(band_h * img_w + 1);
    endfunction

    function automatic int sumx_w(input int img_w, input int band_h);
        return cnt_w(img_w, band_h) + x_w(img_w);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_COMMIT
    } div_state_e;

endpackage

// File: rtl/calc_centroid_bands_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, N_W cycles per
// division; done pulses the cycle after the last quotient bit lands.
module seq_divider #(
    parameter int N_W = 10,
    parameter int D_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] numer,
    input  logic [D_W-1:0] denom,
    output logic [N_W-1:0] quotient,
    output logic           done
);
    localparam int CW = $clog2(N_W + 1);

    logic [N_W-1:0] quot_q, quot_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic [D_W-1:0] den_q, den_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           zero_q, zero_d;
    logic           done_q, done_d;
    logic [D_W:0]   rem_sh;

    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        zero_d = zero_q;
        done_d = 1'b0;
        rem_sh = {rem_q, quot_q[N_W-1]};
        if (!busy_q) begin
            if (start) begin
                quot_d = numer;
                rem_d  = '0;
                den_d  = denom;
                zero_d = (denom == '0);
                cnt_d  = CW'(N_W);
                busy_d = 1'b1;
            end
        end else begin
            // Trial subtract: keep the difference only when it does not borrow.
            if (rem_sh >= {1'b0, den_q}) begin
                rem_d  = D_W'(rem_sh - {1'b0, den_q});
                quot_d = {quot_q[N_W-2:0], 1'b1};
            end else begin
                rem_d  = D_W'(rem_sh);
                quot_d = {quot_q[N_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            zero_q <= zero_d;
            done_q <= done_d;
        end
    end

    assign quotient = zero_q ? '0 : quot_q;
    assign done     = done_q;

endmodule

// File: rtl/calc_centroid_bands.sv
// Per-band white-pixel centroid tracker: accumulates x sums/counts in stacked
// bottom bands, snapshots at frame end and divides band by band off-line.
module calc_centroid_bands
    import centroid_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int PIX_W      = 4,
    parameter int NUM_BANDS  = 4,
    parameter int BAND_H     = 32,
    parameter int THRESHOLD  = 0,
    parameter int MIN_PIXELS = 16,
    localparam int X_W       = x_w(IMG_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_ready,
    input  logic                       sof,
    input  logic [PIX_W-1:0]           pixel_in,
    output logic [NUM_BANDS*X_W-1:0]   centroid_x,
    output logic [NUM_BANDS-1:0]       band_valid,
    output logic [NUM_BANDS-1:0]       band_lost,
    output logic                       results_valid,
    output logic                       busy,
    output logic                       overrun
);
    localparam int CNT_W     = cnt_w(IMG_W, BAND_H);
    localparam int SUMX_W    = sumx_w(IMG_W, BAND_H);
    localparam int Y_W       = $clog2(IMG_H);
    localparam int ROI_START = IMG_H - NUM_BANDS * BAND_H;
    localparam int BI_W      = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int BR_W      = (BAND_H > 1) ? $clog2(BAND_H) : 1;
    localparam int DC_W      = (SUMX_W > 1) ? $clog2(SUMX_W) : 1;
    localparam logic [X_W-1:0] LAST_X = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(IMG_H - 1);

    function automatic logic [X_W-1:0] sat_x(input logic [SUMX_W-1:0] q);
        if (q > SUMX_W'(IMG_W - 1)) return LAST_X;
        return q[X_W-1:0];
    endfunction

    logic [X_W-1:0]    x_q, x_d, cur_x;
    logic [Y_W-1:0]    y_q, y_d, cur_y, y_nx;
    logic              in_roi_q, in_roi_d, cur_in_roi;
    logic [BI_W-1:0]   band_q, band_d, cur_band;
    logic [BR_W-1:0]   brow_q, brow_d, cur_brow;
    logic              white, frame_end;

    logic [SUMX_W-1:0] sum_q[NUM_BANDS], sum_d[NUM_BANDS];
    logic [CNT_W-1:0]  cnt_q[NUM_BANDS], cnt_d[NUM_BANDS];
    logic [SUMX_W-1:0] snap_sum_q[NUM_BANDS], snap_sum_d[NUM_BANDS];
    logic [CNT_W-1:0]  snap_cnt_q[NUM_BANDS], snap_cnt_d[NUM_BANDS];
    logic [X_W-1:0]    stage_q[NUM_BANDS], stage_d[NUM_BANDS];

    div_state_e        state_q, state_d;
    logic [BI_W-1:0]   div_band_q, div_band_d;
    logic [BI_W-1:0]   res_idx_q, res_idx_d;
    logic [DC_W-1:0]   div_cnt_q, div_cnt_d;

    logic [NUM_BANDS*X_W-1:0] centroid_q, centroid_d;
    logic [NUM_BANDS-1:0]     band_valid_q, band_valid_d;
    logic [NUM_BANDS-1:0]     band_lost_q, band_lost_d;
    logic                     results_valid_q, results_valid_d;
    logic                     overrun_q, overrun_d;

    logic              div_start, div_done, lost;
    logic [SUMX_W-1:0] div_numer, div_quot;
    logic [CNT_W-1:0]  div_denom;

    // Pixel stage: raster position, band tracking and live accumulation.
    always_comb begin
        cur_x      = sof ? '0 : x_q;
        cur_y      = sof ? '0 : y_q;
        cur_in_roi = sof ? (ROI_START == 0) : in_roi_q;
        cur_band   = sof ? BI_W'(NUM_BANDS - 1) : band_q;
        cur_brow   = sof ? '0 : brow_q;
        white      = pixel_in > PIX_W'(THRESHOLD);
        frame_end  = in_ready && (cur_x == LAST_X) && (cur_y == LAST_Y);
        x_d        = x_q;
        y_d        = y_q;
        y_nx       = '0;
        in_roi_d   = in_roi_q;
        band_d     = band_q;
        brow_d     = brow_q;
        overrun_d  = 1'b0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            sum_d[b]      = sum_q[b];
            cnt_d[b]      = cnt_q[b];
            snap_sum_d[b] = snap_sum_q[b];
            snap_cnt_d[b] = snap_cnt_q[b];
        end
        if (in_ready) begin
            x_d      = cur_x + X_W'(1);
            y_d      = cur_y;
            in_roi_d = cur_in_roi;
            band_d   = cur_band;
            brow_d   = cur_brow;
            if (cur_x == LAST_X) begin
                x_d  = '0;
                y_nx = (cur_y == LAST_Y) ? '0 : cur_y + Y_W'(1);
                y_d  = y_nx;
                // Band index counts down as rows descend, top band first.
                if (y_nx == Y_W'(ROI_START)) begin
                    in_roi_d = 1'b1;
                    band_d   = BI_W'(NUM_BANDS - 1);
                    brow_d   = '0;
                end else if (y_nx == '0) begin
                    in_roi_d = 1'b0;
                end else if (cur_in_roi) begin
                    if (cur_brow == BR_W'(BAND_H - 1)) begin
                        brow_d = '0;
                        band_d = cur_band - BI_W'(1);
                    end else begin
                        brow_d = cur_brow + BR_W'(1);
                    end
                end
            end
            if (sof) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    sum_d[b] = '0;
                    cnt_d[b] = '0;
                end
            end
            if (white && cur_in_roi) begin
                sum_d[cur_band] = sum_d[cur_band] + SUMX_W'(cur_x);
                cnt_d[cur_band] = cnt_d[cur_band] + CNT_W'(1);
            end
            if (frame_end) begin
                overrun_d = (state_q != ST_IDLE);
                for (int b = 0; b < NUM_BANDS; b++) begin
                    if (state_q == ST_IDLE) begin
                        snap_sum_d[b] = sum_d[b];
                        snap_cnt_d[b] = cnt_d[b];
                    end
                    sum_d[b] = '0;
                    cnt_d[b] = '0;
                end
            end
        end
    end

    // Divide stage: one shared divider walks the snapshot band by band.
    always_comb begin
        state_d         = state_q;
        div_band_d      = div_band_q;
        res_idx_d       = res_idx_q;
        div_cnt_d       = div_cnt_q;
        centroid_d      = centroid_q;
        band_valid_d    = band_valid_q;
        band_lost_d     = band_lost_q;
        results_valid_d = 1'b0;
        div_start       = 1'b0;
        div_numer       = snap_sum_q[div_band_q];
        div_denom       = snap_cnt_q[div_band_q];
        lost            = 1'b0;
        for (int b = 0; b < NUM_BANDS; b++) stage_d[b] = stage_q[b];
        if (div_done) begin
            stage_d[res_idx_q] = sat_x(div_quot);
            res_idx_d          = res_idx_q + BI_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (frame_end) begin
                    state_d    = ST_LOAD;
                    div_band_d = '0;
                    res_idx_d  = '0;
                end
            end
            ST_LOAD: begin
                div_start = 1'b1;
                div_cnt_d = '0;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (div_cnt_q == DC_W'(SUMX_W - 1)) begin
                    if (div_band_q == BI_W'(NUM_BANDS - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        div_band_d = div_band_q + BI_W'(1);
                        state_d    = ST_LOAD;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DC_W'(1);
                end
            end
            default: begin
                // Last band's quotient arrives this cycle via stage_d.
                for (int b = 0; b < NUM_BANDS; b++) begin
                    lost                      = snap_cnt_q[b] < CNT_W'(MIN_PIXELS);
                    centroid_d[b*X_W +: X_W]  = lost ? '0 : stage_d[b];
                    band_valid_d[b]           = !lost;
                    band_lost_d[b]            = lost;
                end
                results_valid_d = 1'b1;
                state_d         = ST_IDLE;
            end
        endcase
    end

    seq_divider #(
        .N_W (SUMX_W),
        .D_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .numer    (div_numer),
        .denom    (div_denom),
        .quotient (div_quot),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q             <= '0;
            y_q             <= '0;
            in_roi_q        <= (ROI_START == 0);
            band_q          <= BI_W'(NUM_BANDS - 1);
            brow_q          <= '0;
            state_q         <= ST_IDLE;
            div_band_q      <= '0;
            res_idx_q       <= '0;
            div_cnt_q       <= '0;
            centroid_q      <= '0;
            band_valid_q    <= '0;
            band_lost_q     <= '1;
            results_valid_q <= 1'b0;
            overrun_q       <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                sum_q[b]      <= '0;
                cnt_q[b]      <= '0;
                snap_sum_q[b] <= '0;
                snap_cnt_q[b] <= '0;
                stage_q[b]    <= '0;
            end
        end else begin
            x_q             <= x_d;
            y_q             <= y_d;
            in_roi_q        <= in_roi_d;
            band_q          <= band_d;
            brow_q          <= brow_d;
            state_q         <= state_d;
            div_band_q      <= div_band_d;
            res_idx_q       <= res_idx_d;
            div_cnt_q       <= div_cnt_d;
            centroid_q      <= centroid_d;
            band_valid_q    <= band_valid_d;
            band_lost_q     <= band_lost_d;
            results_valid_q <= results_valid_d;
            overrun_q       <= overrun_d;
            for (int b = 0; b < NUM_BANDS; b++) begin
                sum_q[b]      <= sum_d[b];
                cnt_q[b]      <= cnt_d[b];
                snap_sum_q[b] <= snap_sum_d[b];
                snap_cnt_q[b] <= snap_cnt_d[b];
                stage_q[b]    <= stage_d[b];
            end
        end
    end

    assign centroid_x    = centroid_q;
    assign band_valid    = band_valid_q;
    assign band_lost     = band_lost_q;
    assign results_valid = results_valid_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_centroid_bands.sv
// Bench for calc_centroid_bands: two configurations, scoreboard of expected
// per-frame results with their expected arrival edge.
module tb_calc_centroid_bands;

    localparam int LA = 23;  // 2 bands * (10+1) + 1
    localparam int LB = 13;  // 2 bands * (5+1) + 1

    typedef struct {
        logic [7:0] cx;
        logic [1:0] v;
        logic [1:0] l;
        int         edge_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       a_rst, a_rdy, a_sof, b_rst, b_rdy, b_sof;
    logic [3:0] a_pix, b_pix;
    logic [7:0] a_cx;
    logic [3:0] b_cx;
    logic [1:0] a_v, a_l, b_v, b_l;
    logic       a_rv, a_busy, a_ov, b_rv, b_busy, b_ov;

    int   errs = 0;
    int   total = 0;
    int   edge_cnt = 0;
    int   b_last = -100000;
    exp_t qa[$];
    exp_t qb[$];
    int   qob[$];
    exp_t ea, eb, last_a, last_b;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    calc_centroid_bands #(
        .IMG_W(16), .IMG_H(8), .PIX_W(4), .NUM_BANDS(2), .BAND_H(2),
        .THRESHOLD(0), .MIN_PIXELS(1)
    ) dut_a (
        .clk(clk), .rst(a_rst), .in_ready(a_rdy), .sof(a_sof), .pixel_in(a_pix),
        .centroid_x(a_cx), .band_valid(a_v), .band_lost(a_l),
        .results_valid(a_rv), .busy(a_busy), .overrun(a_ov)
    );

    calc_centroid_bands #(
        .IMG_W(4), .IMG_H(2), .PIX_W(4), .NUM_BANDS(2), .BAND_H(1),
        .THRESHOLD(0), .MIN_PIXELS(2)
    ) dut_b (
        .clk(clk), .rst(b_rst), .in_ready(b_rdy), .sof(b_sof), .pixel_in(b_pix),
        .centroid_x(b_cx), .band_valid(b_v), .band_lost(b_l),
        .results_valid(b_rv), .busy(b_busy), .overrun(b_ov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int s0, input int c0, input int s1, input int c1,
                                input int xw, input int minp, input int en);
        exp_t e;
        int   s[2];
        int   c[2];
        s[0] = s0; s[1] = s1; c[0] = c0; c[1] = c1;
        e.cx = '0; e.v = '0; e.l = '0;
        for (int b = 0; b < 2; b++) begin
            if (c[b] >= minp) begin
                e.cx = e.cx | 8'((s[b] / c[b]) << (b * xw));
                e.v[b] = 1'b1;
            end else begin
                e.l[b] = 1'b1;
            end
        end
        e.edge_n = en;
        return e;
    endfunction

    function automatic bit white_a(input int pat, input int x, input int y);
        case (pat)
            1: return x == 5 && y >= 4;
            2: return x >= 3 && x <= 6 && y >= 6;
            3: return y <= 3 && (x % 3) == 0;
            4: return x == 9;
            5: return x == 1;
            6: return $urandom_range(0, 1) == 1;
            default: return (y >= 4 && y <= 5 && (x == 2 || x == 11)) || (y >= 6 && x == 7);
        endcase
    endfunction

    // Drives rows 0..rows-1 of a 16x8 frame; the reference band is (7-y)/2.
    task automatic frame_a(input int pat, input int rows, input bit gaps, input bit want);
        int s[2];
        int c[2];
        bit w;
        int b;
        s[0] = 0; s[1] = 0; c[0] = 0; c[1] = 0;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < 16; x++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    a_rdy = 1'b0;
                    a_sof = 1'($urandom_range(0, 1));
                    a_pix = 4'($urandom_range(0, 15));
                end
                @(negedge clk);
                w     = white_a(pat, x, y);
                a_rdy = 1'b1;
                a_sof = (x == 0 && y == 0);
                a_pix = w ? 4'($urandom_range(1, 15)) : 4'd0;
                if (w && y >= 4) begin
                    b = (7 - y) / 2;
                    s[b] += x;
                    c[b]++;
                end
                if (want && x == 15 && y == 7)
                    qa.push_back(mk(s[0], c[0], s[1], c[1], 4, 1, edge_cnt + 1 + LA));
            end
        end
        @(negedge clk);
        a_rdy = 1'b0;
        a_sof = 1'b0;
        a_pix = 4'd0;
    endtask

    // 4x2 frame, random pixels, optional in_ready gap before the last pixel.
    task automatic frame_b(input int gap);
        int s[2];
        int c[2];
        bit w;
        int f;
        s[0] = 0; s[1] = 0; c[0] = 0; c[1] = 0;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (y == 1 && x == 3) begin
                    repeat (gap) begin
                        @(negedge clk);
                        b_rdy = 1'b0;
                        b_sof = 1'b0;
                        b_pix = 4'($urandom_range(0, 15));
                    end
                end
                @(negedge clk);
                w     = ($urandom_range(0, 1) == 1);
                b_rdy = 1'b1;
                b_sof = (x == 0 && y == 0);
                b_pix = w ? 4'($urandom_range(1, 15)) : 4'd0;
                if (w) begin
                    s[1 - y] += x;
                    c[1 - y]++;
                end
                if (x == 3 && y == 1) begin
                    f = edge_cnt + 1;
                    if (f > b_last + LB) begin
                        qb.push_back(mk(s[0], c[0], s[1], c[1], 2, 2, f + LB));
                        b_last = f;
                    end else begin
                        qob.push_back(f);
                    end
                end
            end
        end
    endtask

    task automatic drain_a(input int bound);
        int n = 0;
        while (qa.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("a_drain", 32'(qa.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("a_hold_cx", 32'(a_cx), 32'(last_a.cx));
        chk("a_hold_valid", 32'(a_v), 32'(last_a.v));
        chk("a_hold_lost", 32'(a_l), 32'(last_a.l));
    endtask

    always @(negedge clk) begin
        if (a_rv === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_rv_unexpected", 32'(a_rv), 32'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_latency", 32'(edge_cnt), 32'(ea.edge_n));
                chk("a_centroid", 32'(a_cx), 32'(ea.cx));
                chk("a_valid", 32'(a_v), 32'(ea.v));
                chk("a_lost", 32'(a_l), 32'(ea.l));
                chk("a_busy_at_commit", 32'(a_busy), 32'd0);
                last_a = ea;
            end
        end
        if (a_ov === 1'b1) chk("a_overrun_unexpected", 32'(a_ov), 32'd0);
        if (b_rv === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_rv_unexpected", 32'(b_rv), 32'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_latency", 32'(edge_cnt), 32'(eb.edge_n));
                chk("b_centroid", 32'(b_cx), 32'(eb.cx));
                chk("b_valid", 32'(b_v), 32'(eb.v));
                chk("b_lost", 32'(b_l), 32'(eb.l));
                last_b = eb;
            end
        end
        if (b_ov === 1'b1) begin
            if (qob.size() == 0) chk("b_overrun_unexpected", 32'(b_ov), 32'd0);
            else chk("b_overrun_edge", 32'(edge_cnt), 32'(qob.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        a_rst = 1'b1; b_rst = 1'b1;
        a_rdy = 1'b0; a_sof = 1'b0; a_pix = 4'd0;
        b_rdy = 1'b0; b_sof = 1'b0; b_pix = 4'd0;
        repeat (2) @(negedge clk);
        chk("a_reset_cx", 32'(a_cx), 32'd0);
        chk("a_reset_valid", 32'(a_v), 32'd0);
        chk("a_reset_lost", 32'(a_l), 32'd3);
        chk("a_reset_rv", 32'(a_rv), 32'd0);
        chk("a_reset_busy", 32'(a_busy), 32'd0);
        chk("a_reset_overrun", 32'(a_ov), 32'd0);
        chk("b_reset_cx", 32'(b_cx), 32'd0);
        chk("b_reset_valid", 32'(b_v), 32'd0);
        chk("b_reset_lost", 32'(b_l), 32'd3);
        chk("b_reset_busy", 32'(b_busy), 32'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Column 5 in both bands.
        frame_a(1, 8, 1'b0, 1'b1);
        chk("a_busy_after_frame_end", 32'(a_busy), 32'd1);
        drain_a(100);

        // Band 0 only, band 1 empty.
        frame_a(2, 8, 1'b0, 1'b1);
        drain_a(100);

        // Whites above the ROI only, with in_ready gaps.
        frame_a(3, 8, 1'b1, 1'b1);
        drain_a(100);

        // Partial frame abandoned by sof, then a full frame on column 9.
        frame_a(5, 5, 1'b0, 1'b0);
        frame_a(4, 8, 1'b0, 1'b1);
        drain_a(100);

        // Random content with gaps.
        frame_a(6, 8, 1'b1, 1'b1);
        drain_a(100);
        frame_a(6, 8, 1'b0, 1'b1);
        drain_a(100);

        // Reset five cycles into the division.
        frame_a(7, 8, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("a_midrst_cx", 32'(a_cx), 32'd0);
        chk("a_midrst_valid", 32'(a_v), 32'd0);
        chk("a_midrst_lost", 32'(a_l), 32'd3);
        chk("a_midrst_busy", 32'(a_busy), 32'd0);
        chk("a_midrst_rv", 32'(a_rv), 32'd0);
        @(negedge clk);
        a_rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("a_after_rst_busy", 32'(a_busy), 32'd0);
        frame_a(7, 8, 1'b0, 1'b1);
        drain_a(100);

        // Back-to-back small frames; the fourth ends exactly on COMMIT.
        frame_b(0);
        frame_b(0);
        frame_b(0);
        frame_b(5);
        frame_b(0);
        @(negedge clk);
        b_rdy = 1'b0; b_sof = 1'b0; b_pix = 4'd0;
        n = 0;
        while ((qb.size() != 0 || qob.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_drain_results", 32'(qb.size()), 32'd0);
        chk("b_drain_overruns", 32'(qob.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("b_hold_cx", 32'(b_cx), 32'(last_b.cx));
        chk("b_idle_busy", 32'(b_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule
